// File: rtl/mips_defs.sv
// ------------------------------------------------------------------
// mips_defs : shared opcodes, ALU op codes and forwarding selects
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mips_defs;

   localparam int N_BITS_DEF = 32;
   localparam int N_REG_DEF  = 5;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_NOP  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_LUI  = 6'b001111;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   typedef enum logic [1:0] {
      FWD_ID    = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwd_sel_t;

   // I-type opcodes reuse the R-type funct encoding as the ALU op code.
   function automatic logic [5:0] alu_op_sel(input logic [5:0] opcode, input logic [5:0] funct);
      case (opcode)
         OP_RTYPE:               alu_op_sel = funct;
         OP_ADDI, OP_LW, OP_SW:  alu_op_sel = FN_ADD;
         OP_ANDI:                alu_op_sel = FN_AND;
         OP_ORI:                 alu_op_sel = FN_OR;
         OP_XORI:                alu_op_sel = FN_XOR;
         OP_SLTI:                alu_op_sel = FN_SLT;
         OP_LUI:                 alu_op_sel = FN_LUI;
         default:                alu_op_sel = FN_NOP;
      endcase
   endfunction

   function automatic logic is_shift(input logic [5:0] opcode, input logic [5:0] funct);
      is_shift = (opcode == OP_RTYPE) && ((funct == FN_SRL) || (funct == FN_SRA));
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ------------------------------------------------------------------
// alu : combinational ALU keyed by the R-type funct encoding
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module alu
   import mips_defs::*;
#(
   parameter int N_BITS = 32
) (
   input  logic [N_BITS-1:0] i_a,
   input  logic [N_BITS-1:0] i_b,
   input  logic [5:0]        i_op,
   output logic [N_BITS-1:0] o_y
);

   localparam int SH_W = $clog2(N_BITS);

   always_comb begin
      o_y = '0;
      case (i_op)
         FN_ADD, FN_ADDU: o_y = i_a + i_b;
         FN_SUB, FN_SUBU: o_y = i_a - i_b;
         FN_AND:          o_y = i_a & i_b;
         FN_OR:           o_y = i_a | i_b;
         FN_XOR:          o_y = i_a ^ i_b;
         FN_NOR:          o_y = ~(i_a | i_b);
         FN_SLT:          o_y = {{(N_BITS-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         FN_SLTU:         o_y = {{(N_BITS-1){1'b0}}, (i_a < i_b)};
         FN_SRL:          o_y = i_a >> i_b[SH_W-1:0];
         FN_SRA:          o_y = $signed(i_a) >>> i_b[SH_W-1:0];
         FN_LUI:          o_y = i_b << (N_BITS/2);
         default:         o_y = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/forwarding_unit.sv
// ------------------------------------------------------------------
// forwarding_unit : operand source select for rs and rt
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module forwarding_unit
   import mips_defs::*;
#(
   parameter int N_REG = 5
) (
   input  logic             i_exmem_wr,
   input  logic [N_REG-1:0] i_exmem_rd,
   input  logic             i_memwb_wr,
   input  logic [N_REG-1:0] i_memwb_rd,
   input  logic [N_REG-1:0] i_rs_addr,
   input  logic [N_REG-1:0] i_rt_addr,
   output fwd_sel_t         o_rs_sel,
   output fwd_sel_t         o_rt_sel
);

   // The newer EX/MEM result shadows MEM/WB; r0 is hard-wired and never forwarded.
   function automatic fwd_sel_t pick(input logic [N_REG-1:0] src);
      if (i_exmem_wr && (i_exmem_rd != '0) && (i_exmem_rd == src))
         pick = FWD_EXMEM;
      else if (i_memwb_wr && (i_memwb_rd != '0) && (i_memwb_rd == src))
         pick = FWD_MEMWB;
      else
         pick = FWD_ID;
   endfunction

   always_comb begin
      o_rs_sel = pick(i_rs_addr);
      o_rt_sel = pick(i_rt_addr);
   end

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ------------------------------------------------------------------
// ex_stage : MIPS execute stage, forwarding and EX/MEM register
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module ex_stage
   import mips_defs::*;
#(
   parameter int N_BITS = N_BITS_DEF,
   parameter int N_REG  = N_REG_DEF
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid,
   input  logic [5:0]        i_opcode,
   input  logic [5:0]        i_funct,
   input  logic [4:0]        i_shamt,
   input  logic [N_BITS-1:0] i_rs_data,
   input  logic [N_BITS-1:0] i_rt_data,
   input  logic [N_BITS-1:0] i_imm,
   input  logic [N_REG-1:0]  i_rs_addr,
   input  logic [N_REG-1:0]  i_rt_addr,
   input  logic [N_REG-1:0]  i_rd_addr,
   input  logic              i_reg_dst,
   input  logic              i_alu_src,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic              i_reg_write,
   input  logic              i_mem_to_reg,
   input  logic              i_memwb_reg_write,
   input  logic [N_REG-1:0]  i_memwb_rd,
   input  logic [N_BITS-1:0] i_memwb_data,
   input  logic              i_stall,
   input  logic              i_flush,
   output logic              o_valid,
   output logic [N_BITS-1:0] o_alu_result,
   output logic [N_BITS-1:0] o_store_data,
   output logic [N_REG-1:0]  o_rd,
   output logic              o_mem_read,
   output logic              o_mem_write,
   output logic              o_reg_write,
   output logic              o_mem_to_reg,
   output logic              o_load_use
);

   typedef struct packed {
      logic              valid;
      logic [N_BITS-1:0] alu_result;
      logic [N_BITS-1:0] store_data;
      logic [N_REG-1:0]  rd;
      logic              mem_read;
      logic              mem_write;
      logic              reg_write;
      logic              mem_to_reg;
   } exmem_t;

   exmem_t exmem_d, exmem_q, slot_new;

   fwd_sel_t          rs_sel, rt_sel;
   logic [N_BITS-1:0] rs_fwd, rt_fwd, op_a, op_b, alu_y;
   logic [5:0]        alu_op;
   logic              shift_op;

   forwarding_unit #(.N_REG(N_REG)) u_fwd (
      .i_exmem_wr (exmem_q.valid & exmem_q.reg_write),
      .i_exmem_rd (exmem_q.rd),
      .i_memwb_wr (i_memwb_reg_write),
      .i_memwb_rd (i_memwb_rd),
      .i_rs_addr  (i_rs_addr),
      .i_rt_addr  (i_rt_addr),
      .o_rs_sel   (rs_sel),
      .o_rt_sel   (rt_sel)
   );

   always_comb begin
      case (rs_sel)
         FWD_EXMEM: rs_fwd = exmem_q.alu_result;
         FWD_MEMWB: rs_fwd = i_memwb_data;
         default:   rs_fwd = i_rs_data;
      endcase
      case (rt_sel)
         FWD_EXMEM: rt_fwd = exmem_q.alu_result;
         FWD_MEMWB: rt_fwd = i_memwb_data;
         default:   rt_fwd = i_rt_data;
      endcase

      alu_op   = alu_op_sel(i_opcode, i_funct);
      shift_op = is_shift(i_opcode, i_funct);
      // Shifts take the value from rt and the amount from shamt.
      op_a     = shift_op ? rt_fwd : rs_fwd;
      op_b     = shift_op ? {{(N_BITS-5){1'b0}}, i_shamt}
                          : (i_alu_src ? i_imm : rt_fwd);
   end

   alu #(.N_BITS(N_BITS)) u_alu (
      .i_a  (op_a),
      .i_b  (op_b),
      .i_op (alu_op),
      .o_y  (alu_y)
   );

   always_comb begin
      slot_new = '0;
      if (i_valid) begin
         slot_new.valid      = 1'b1;
         slot_new.alu_result = alu_y;
         slot_new.store_data = rt_fwd;
         slot_new.rd         = i_reg_dst ? i_rd_addr : i_rt_addr;
         slot_new.mem_read   = i_mem_read;
         slot_new.mem_write  = i_mem_write;
         slot_new.reg_write  = i_reg_write;
         slot_new.mem_to_reg = i_mem_to_reg;
      end

      exmem_d = exmem_q;
      if (i_flush)
         exmem_d = '0;
      else if (!i_stall)
         exmem_d = slot_new;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset)
         exmem_q <= '0;
      else
         exmem_q <= exmem_d;
   end

   assign o_valid      = exmem_q.valid;
   assign o_alu_result = exmem_q.alu_result;
   assign o_store_data = exmem_q.store_data;
   assign o_rd         = exmem_q.rd;
   assign o_mem_read   = exmem_q.mem_read;
   assign o_mem_write  = exmem_q.mem_write;
   assign o_reg_write  = exmem_q.reg_write;
   assign o_mem_to_reg = exmem_q.mem_to_reg;

   // A load in EX/MEM only holds its address, so a dependent consumer must wait.
   assign o_load_use = exmem_q.valid & exmem_q.mem_read & (exmem_q.rd != '0)
                     & ((exmem_q.rd == i_rs_addr) | (exmem_q.rd == i_rt_addr)) & i_valid;

endmodule

`default_nettype wire
